// File: rtl/keypad_shuffle_map.sv
// rtl/keypad_shuffle_map.sv - keypad digit-to-key scrambler using a seedable LFSR-driven Fisher-Yates shuffle
//
// Keeps a permutation of digits 0..N_KEYS-1, one per physical key position.
// A shuffle request rebuilds the permutation from identity. It then performs
// one Fisher-Yates swap per cycle, from the highest index down to index 1.
// Lookups are combinational. They are withheld while a shuffle is running.
//
// Ports:
//   clk              system clock
//   rstn             synchronous active-low reset
//   seed_load_i      load seed_i into the LFSR (honoured only when idle)
//   seed_i           seed value; zero selects SEED_DEF
//   shuffle_start_i  request a new permutation (honoured only when idle)
//   busy_o           shuffle in progress
//   done_o           one-cycle pulse on the first idle cycle after a shuffle
//   key_index_i      key position to look up
//   digit_o          digit at key_index_i, zero when not valid
//   digit_valid_o    key_index_i in range and no shuffle running

module keypad_shuffle_map #(
    parameter int                N_KEYS    = 10,
    parameter int                DW        = 4,
    parameter int                LFSR_W    = 16,
    parameter int                R_W       = 8,
    parameter logic [LFSR_W-1:0] SEED_DEF  = LFSR_W'(16'hACE1),
    // Galois toggle mask for x^16+x^14+x^13+x^11+1
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              shuffle_start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DW-1:0]     key_index_i,
    output logic [DW-1:0]     digit_o,
    output logic              digit_valid_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SWAP = 1'b1
    } state_t;

    // The map covers the whole index space, so any key_index_i can address it
    // directly. Entries at N_KEYS and above stay at zero and are never swapped.
    localparam int N_MAP = 2 ** DW;
    localparam int PW    = R_W + DW;

    state_t            state_q, state_d;
    logic [DW-1:0]     map_q [N_MAP];
    logic [DW-1:0]     map_d [N_MAP];
    logic [DW-1:0]     i_q, i_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              done_q, done_d;
    logic [LFSR_W-1:0] lfsr_shift;
    logic [DW-1:0]     j;

    always_comb begin
        lfsr_shift = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    // Scale the R_W-bit draw into 0..i by multiplying by i+1 and keeping the
    // top bits. The product spans R_W+DW bits, so nothing is lost before the
    // shift.
    always_comb begin
        j = DW'((PW'(lfsr_q[R_W-1:0]) * (PW'(i_q) + PW'(1))) >> R_W);
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        done_d  = 1'b0;
        lfsr_d  = lfsr_shift;
        map_d   = map_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load_i) begin
                    lfsr_d = (seed_i == '0) ? SEED_DEF : seed_i;
                end else if (shuffle_start_i) begin
                    for (int k = 0; k < N_MAP; k++) begin
                        map_d[k] = (k < N_KEYS) ? DW'(k) : '0;
                    end
                    i_d     = DW'(N_KEYS - 1);
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                map_d[i_q] = map_q[j];
                map_d[j]   = map_q[i_q];
                i_d        = i_q - DW'(1);
                if (i_q == DW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            lfsr_q  <= SEED_DEF;
            done_q  <= 1'b0;
            for (int k = 0; k < N_MAP; k++) begin
                map_q[k] <= (k < N_KEYS) ? DW'(k) : '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
            map_q   <= map_d;
        end
    end

    always_comb begin
        busy_o        = (state_q == S_SWAP);
        done_o        = done_q;
        digit_valid_o = (int'(key_index_i) < N_KEYS) && (state_q == S_IDLE);
        digit_o       = digit_valid_o ? map_q[key_index_i] : '0;
    end

endmodule
